// File: rtl/adf_pkg.sv
// Shared definitions for the ADF4350 serial write path: FSM state encoding,
// register word width and the ADF4350 control-bit codes.
package adf_pkg;

  localparam int ADF_WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    TAIL  = 3'd3,
    LATCH = 3'd4,
    GAP   = 3'd5
  } adf_state_e;

  localparam logic [2:0] REG0 = 3'd0;
  localparam logic [2:0] REG1 = 3'd1;
  localparam logic [2:0] REG2 = 3'd2;
  localparam logic [2:0] REG3 = 3'd3;
  localparam logic [2:0] REG4 = 3'd4;
  localparam logic [2:0] REG5 = 3'd5;

  // Largest of three cycle counts; sizes the shared timed-state counter.
  function automatic int adf_max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/adf4350_spi_writer_if.sv
// Word handshake between the ADF register sequencer (master) and the serial
// write engine (slave). ADF_SPI_DUAL_EN adds the TARGET select.
interface adf4350_spi_writer_if;

  logic [adf_pkg::ADF_WORD_W-1:0] WORD;
  logic                           WORD_VALID;
  logic                           WORD_READY;

`ifdef ADF_SPI_DUAL_EN
  logic TARGET;

  modport master (output WORD, output WORD_VALID, output TARGET, input WORD_READY);
  modport slave  (input WORD, input WORD_VALID, input TARGET, output WORD_READY);
`else
  modport master (output WORD, output WORD_VALID, input WORD_READY);
  modport slave  (input WORD, input WORD_VALID, output WORD_READY);
`endif

endinterface

// File: rtl/adf4350_spi_writer.sv
// ADF4350 serial write engine: shifts one 32-bit word MSB-first on D_CLK/D_OUT,
// then pulses D_LE. Define ADF_SPI_DUAL_EN for a second (LO) output triplet.
module adf4350_spi_writer
  import adf_pkg::*;
#(
  parameter int CLK_DIV    = 5,
  parameter int LE_WIDTH   = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  adf4350_spi_writer_if.slave       bus,
  output logic                      D_CLK,
  output logic                      D_OUT,
  output logic                      D_LE,
`ifdef ADF_SPI_DUAL_EN
  output logic                      LO_D_CLK,
  output logic                      LO_D_OUT,
  output logic                      LO_D_LE,
`endif
  output logic                      BUSY,
  output logic                      DONE
);

  localparam int CNT_W = $clog2(adf_max3(CLK_DIV, LE_WIDTH, GAP_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LE_LOAD  = CNT_W'(LE_WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  adf_state_e              state_r, state_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [ADF_WORD_W-1:0]   shreg_r, shreg_s;
  logic [4:0]              bit_r, bit_s;
  logic                    ready_r, ready_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic                    dclk_s, dout_s, dle_s;
  logic                    rf_dclk_r, rf_dclk_s;
  logic                    rf_dout_r, rf_dout_s;
  logic                    rf_dle_r, rf_dle_s;
  logic                    cnt_zero_s;
`ifdef ADF_SPI_DUAL_EN
  logic                    tgt_r, tgt_s;
  logic                    lo_dclk_r, lo_dclk_s;
  logic                    lo_dout_r, lo_dout_s;
  logic                    lo_dle_r, lo_dle_s;
`endif

  assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});

  // Next-state and next-output decode; outputs are computed from the next state
  // so that the registered pins line up with the state they describe.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    shreg_s = shreg_r;
    bit_s   = bit_r;
    ready_s = 1'b0;
    busy_s  = 1'b1;
    done_s  = 1'b0;
    dclk_s  = 1'b0;
    dle_s   = 1'b0;
`ifdef ADF_SPI_DUAL_EN
    tgt_s   = tgt_r;
`endif
    case (state_r)
      IDLE: begin
        if (bus.WORD_VALID) begin
          state_s = SETUP;
          cnt_s   = DIV_LOAD;
          shreg_s = bus.WORD;
          bit_s   = 5'd31;
`ifdef ADF_SPI_DUAL_EN
          tgt_s   = bus.TARGET;
`endif
        end else begin
          ready_s = 1'b1;
          busy_s  = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_zero_s) begin
          state_s = HIGH;
          cnt_s   = DIV_LOAD;
          dclk_s  = 1'b1;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      HIGH: begin
        if (cnt_zero_s) begin
          cnt_s = DIV_LOAD;
          if (bit_r == 5'd0) begin
            state_s = TAIL;
          end else begin
            state_s = SETUP;
            shreg_s = {shreg_r[ADF_WORD_W-2:0], 1'b0};
            bit_s   = bit_r - 5'd1;
          end
        end else begin
          cnt_s  = cnt_r - CNT_ONE;
          dclk_s = 1'b1;
        end
      end
      TAIL: begin
        if (cnt_zero_s) begin
          state_s = LATCH;
          cnt_s   = LE_LOAD;
          dle_s   = 1'b1;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      LATCH: begin
        if (cnt_zero_s) begin
          done_s = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_s = GAP;
            cnt_s   = GAP_LOAD;
          end else begin
            state_s = IDLE;
            ready_s = 1'b1;
            busy_s  = 1'b0;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
          dle_s = 1'b1;
        end
      end
      GAP: begin
        if (cnt_zero_s) begin
          state_s = IDLE;
          ready_s = 1'b1;
          busy_s  = 1'b0;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        ready_s = 1'b1;
        busy_s  = 1'b0;
      end
    endcase

    // D_OUT holds the current MSB from SETUP through LATCH, zero otherwise.
    if ((state_s == SETUP) || (state_s == HIGH) || (state_s == TAIL) || (state_s == LATCH)) begin
      dout_s = shreg_s[ADF_WORD_W-1];
    end else begin
      dout_s = 1'b0;
    end

`ifdef ADF_SPI_DUAL_EN
    rf_dclk_s = dclk_s & ~tgt_s;
    rf_dout_s = dout_s & ~tgt_s;
    rf_dle_s  = dle_s  & ~tgt_s;
    lo_dclk_s = dclk_s & tgt_s;
    lo_dout_s = dout_s & tgt_s;
    lo_dle_s  = dle_s  & tgt_s;
`else
    rf_dclk_s = dclk_s;
    rf_dout_s = dout_s;
    rf_dle_s  = dle_s;
`endif
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      shreg_r   <= {ADF_WORD_W{1'b0}};
      bit_r     <= 5'd0;
      ready_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rf_dclk_r <= 1'b0;
      rf_dout_r <= 1'b0;
      rf_dle_r  <= 1'b0;
`ifdef ADF_SPI_DUAL_EN
      tgt_r     <= 1'b0;
      lo_dclk_r <= 1'b0;
      lo_dout_r <= 1'b0;
      lo_dle_r  <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      shreg_r   <= shreg_s;
      bit_r     <= bit_s;
      ready_r   <= ready_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      rf_dclk_r <= rf_dclk_s;
      rf_dout_r <= rf_dout_s;
      rf_dle_r  <= rf_dle_s;
`ifdef ADF_SPI_DUAL_EN
      tgt_r     <= tgt_s;
      lo_dclk_r <= lo_dclk_s;
      lo_dout_r <= lo_dout_s;
      lo_dle_r  <= lo_dle_s;
`endif
    end
  end

  assign bus.WORD_READY = ready_r;
  assign BUSY           = busy_r;
  assign DONE           = done_r;
  assign D_CLK          = rf_dclk_r;
  assign D_OUT          = rf_dout_r;
  assign D_LE           = rf_dle_r;
`ifdef ADF_SPI_DUAL_EN
  assign LO_D_CLK       = lo_dclk_r;
  assign LO_D_OUT       = lo_dout_r;
  assign LO_D_LE        = lo_dle_r;
`endif

endmodule

// File: doc/adf4350_spi_writer.md
Name: adf4350_spi_writer

Overview:
- Serial write engine for the ADF4350 synthesizers, directly downstream of the ADF register sequencer.
- Accepts one 32-bit register word per valid/ready handshake.
- Shifts the word MSB-first onto D_CLK/D_OUT, then pulses D_LE to latch it.
- Runs on the 50 MHz fabric clock; all interface timing is derived from parameterised cycle counts.

Parameters:
- CLK_DIV, 5: CLK cycles per D_CLK half-period (min 1); 50 MHz/(2*5) = 5 MHz SCLK.
- LE_WIDTH, 4: CLK cycles D_LE is held high (min 1).
- GAP_CYCLES, 8: idle CLK cycles after D_LE falls before the next word is accepted (min 0).

Ports:
- CLK  input  1  fabric clock (50 MHz).
- RST  input  1  synchronous, active-low reset, sampled on rising CLK.
- WORD  input  32  register word; bits [2:0] are the ADF4350 control bits, sent last.
- WORD_VALID  input  1  WORD is presented.
- WORD_READY  output  1  engine can accept a word.
- D_CLK  output  1  serial clock to the ADF4350.
- D_OUT  output  1  serial data, changes only while D_CLK is low.
- D_LE  output  1  load enable, high pulse after the 32nd bit.
- BUSY  output  1  high from acceptance until the gap ends.
- DONE  output  1  one-cycle pulse when D_LE falls.

Behaviour:
- All outputs are registered. Reset values: WORD_READY=0, D_CLK=0, D_OUT=0, D_LE=0, BUSY=0, DONE=0. State=IDLE.
- WORD_READY=1 only in IDLE. Acceptance occurs on a cycle with WORD_VALID & WORD_READY. WORD is captured into a 32-bit shift register and the bit counter is set to 31.
- States and transitions:
  - IDLE: on acceptance, next state SETUP. D_OUT drives WORD[31] from the next cycle. BUSY=1 and WORD_READY=0 from the next cycle.
  - SETUP (D_CLK=0, CLK_DIV cycles), then HIGH.
  - HIGH (D_CLK=1, CLK_DIV cycles). The device samples on the D_CLK rising edge. At the end of HIGH:
    - if bit counter is 0, go to TAIL;
    - otherwise shift left, decrement the counter, put the next bit on D_OUT, and go to SETUP.
  - TAIL (D_CLK=0, CLK_DIV cycles; D_OUT holds bit 0), then LATCH.
  - LATCH (D_LE=1, LE_WIDTH cycles). On exit, D_LE=0, DONE=1 for one cycle, D_OUT=0, and state goes to GAP.
  - GAP (GAP_CYCLES cycles, skipped if 0), then IDLE. BUSY falls on entry to IDLE.
- Timing:
  - Exactly 32 D_CLK rising edges per word.
  - D_OUT is stable for CLK_DIV cycles before each rising edge and CLK_DIV cycles after it.
  - Acceptance to DONE = 1 + 64*CLK_DIV + CLK_DIV + LE_WIDTH cycles. Default: 1+320+5+4 = 330.
- D_LE never rises unless all 32 bits have been shifted.
- WORD_VALID while busy is ignored (not queued). WORD may change freely once accepted.
- Reset mid-operation: on the next rising CLK, all outputs take their reset values. A partial word is discarded with no D_LE pulse and no DONE.
- One down-counter, width clog2(max(CLK_DIV, LE_WIDTH, GAP_CYCLES))+1, is shared by all timed states.

Optional Feature:
- Macro ADF_SPI_DUAL_EN.
- Defined:
  - Adds input TARGET (1 bit), sampled at acceptance; 0=RF synthesizer, 1=LO synthesizer.
  - Adds outputs LO_D_CLK, LO_D_OUT, LO_D_LE.
  - The captured TARGET routes the serial activity to one output triplet; the unselected triplet stays 0.
  - Timing is identical to single mode.
- Undefined: single triplet only; no TARGET port.

Decomposition:
- Shared package adf_pkg:
  - state encoding localparams (IDLE, SETUP, HIGH, TAIL, LATCH, GAP);
  - ADF_WORD_W=32;
  - ADF4350 control-bit constants REG0..REG5 (3'd0..3'd5).
- No sub-module needed. The timed-state down-counter is inline.
- The register sequencer instantiates this block once, or once per synthesizer when the dual feature is not used.

Test Plan:
1. Defaults, WORD=0x00580005 held valid one cycle -> exactly 32 D_CLK rises; bits sampled on rising edges reconstruct 0x00580005 MSB-first; D_LE high 4 cycles starting 5 cycles after the last fall; DONE at cycle 330.
2. CLK_DIV=1, LE_WIDTH=1, GAP_CYCLES=0, WORD=0xFFFFFFFF then 0x00000000 back-to-back (WORD_VALID held high) -> second word accepted on the first cycle BUSY=0 after DONE; D_CLK toggles every cycle; bits correct.
3. WORD_VALID pulsed with a different value at cycle 100 during a transfer -> ignored; WORD_READY=0; only the first word is shifted.
4. RST low at cycle 150 of a transfer -> next cycle all outputs 0; D_LE never rises; after RST high, a new word 0x000004B3 transfers correctly.
5. ADF_SPI_DUAL_EN, TARGET=1, WORD=0x00400004 -> LO_* triplet carries the word; D_CLK/D_OUT/D_LE remain 0 throughout; then TARGET=0 routes to the RF triplet.
6. Alternating pattern 0xAAAAAAAA -> D_OUT changes only while D_CLK=0, never within CLK_DIV cycles before a rising edge.
